if_stage: RTL and testbench

- Instruction-fetch stage: owns the architectural PC register and the IF/ID pipeline register.
- Drives `curr_pc` into the next-PC calculator and consumes its `next_pc` result.
- Issues req/ack fetches to instruction memory and hands `{pc, instr, valid}` to decode.
- Absorbs hazard-unit stalls and branch/jump flushes without losing or duplicating instructions.

---
 rtl/if_stage_pkg.sv | 15 +
 rtl/if_stage_ifid_reg.sv | 43 ++++
 rtl/if_stage.sv | 148 ++++++++++++++
 tb/tb_if_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared encodings and defaults for the instruction-fetch stage.
// The optional IF_PERF_CNT_EN build adds performance counters to if_stage.
package if_stage_pkg;

    typedef enum logic [1:0] {
        IF_S_IDLE  = 2'd0,
        IF_S_FETCH = 2'd1,
        IF_S_HOLD  = 2'd2,
        IF_S_DROP  = 2'd3
    } if_state_e;

    localparam logic [31:0] IF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] IF_NOP      = 32'h0000_0000;

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register: load, hold or invalidate, with NOP substitution
// so the instruction word reads as NOP whenever the slot is empty.
module ifid_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = IF_NOP
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        kill,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_valid
);

    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic        valid_reg;

    // kill outranks load so a flush can never let a word through
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_reg    <= 32'h0;
            instr_reg <= NOP_INSTR;
            valid_reg <= 1'b0;
        end else if (kill) begin
            instr_reg <= NOP_INSTR;
            valid_reg <= 1'b0;
        end else if (load) begin
            pc_reg    <= load_pc;
            instr_reg <= load_instr;
            valid_reg <= 1'b1;
        end
    end

    assign id_pc    = pc_reg;
    assign id_instr = instr_reg;
    assign id_valid = valid_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and IF/ID register, runs req/ack fetches.
// Define IF_PERF_CNT_EN to add the perf_fetched / perf_stall counters.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = IF_NOP
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] curr_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    if_state_e   state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] hold_buf_reg, hold_buf_next;
    logic        ifid_load;
    logic        ifid_kill;
    logic [31:0] ifid_instr_in;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IF_S_IDLE;
            pc_reg       <= RESET_PC;
            addr_reg     <= RESET_PC;
            hold_buf_reg <= 32'h0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            addr_reg     <= addr_next;
            hold_buf_reg <= hold_buf_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        addr_next     = addr_reg;
        hold_buf_next = hold_buf_reg;
        ifid_load     = 1'b0;
        ifid_kill     = 1'b0;
        ifid_instr_in = imem_rdata;
        case (state_reg)
            IF_S_IDLE: begin
                state_next = IF_S_FETCH;
                addr_next  = pc_reg;
            end
            IF_S_FETCH: begin
                if (flush) begin
                    // without an ack the bus must keep the stale address until it answers
                    ifid_kill = 1'b1;
                    pc_next   = next_pc;
                    if (imem_ack) addr_next  = next_pc;
                    else          state_next = IF_S_DROP;
                end else if (imem_ack) begin
                    if (stall) begin
                        hold_buf_next = imem_rdata;
                        state_next    = IF_S_HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        pc_next   = next_pc;
                        addr_next = next_pc;
                    end
                end else if (!stall) begin
                    ifid_kill = 1'b1;
                end
            end
            IF_S_HOLD: begin
                if (flush) begin
                    ifid_kill     = 1'b1;
                    hold_buf_next = 32'h0;
                    pc_next       = next_pc;
                    addr_next     = next_pc;
                    state_next    = IF_S_FETCH;
                end else if (!stall) begin
                    ifid_load     = 1'b1;
                    ifid_instr_in = hold_buf_reg;
                    pc_next       = next_pc;
                    addr_next     = next_pc;
                    state_next    = IF_S_FETCH;
                end
            end
            IF_S_DROP: begin
                // wrong-path data is swallowed; a repeated flush only retargets the PC
                ifid_kill = 1'b1;
                if (flush) pc_next = next_pc;
                if (imem_ack) begin
                    addr_next  = flush ? next_pc : pc_reg;
                    state_next = IF_S_FETCH;
                end
            end
            default: state_next = IF_S_IDLE;
        endcase
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (ifid_load),
        .kill       (ifid_kill),
        .load_pc    (pc_reg),
        .load_instr (ifid_instr_in),
        .id_pc      (id_pc),
        .id_instr   (id_instr),
        .id_valid   (id_valid)
    );

    assign curr_pc   = pc_reg;
    assign imem_addr = addr_reg;
    assign imem_req  = (state_reg == IF_S_FETCH) || (state_reg == IF_S_DROP);

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_fetched_reg <= 32'h0;
            perf_stall_reg   <= 32'h0;
        end else begin
            if (ifid_load) perf_fetched_reg <= perf_fetched_reg + 32'd1;
            if (stall && (state_reg != IF_S_IDLE)) perf_stall_reg <= perf_stall_reg + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_stall   = perf_stall_reg;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic
// compared against a transaction-level model of the fetch rules.
module tb_if_stage;

    localparam logic [31:0] RPC = 32'h0000_3000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n, stall, flush, imem_ack;
    logic [31:0] next_pc, imem_rdata;
    logic [31:0] curr_pc, imem_addr, id_pc, id_instr;
    logic        imem_req, id_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    int total = 0;
    int bad   = 0;

    // model: pc / fetch address, IF/ID contents, and three situation flags
    logic [31:0] m_pc, m_addr, m_idpc, m_idinstr, m_buf;
    bit          m_valid, m_req, m_started, m_buffered, m_dropping;

    always #5 clk = ~clk;

    if_stage dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .next_pc    (next_pc),
        .stall      (stall),
        .flush      (flush),
        .curr_pc    (curr_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .id_pc      (id_pc),
        .id_instr   (id_instr),
        .id_valid   (id_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    // drive one cycle of inputs, advance past the edge, and update the model
    task automatic tick(input bit rn, input bit st, input bit fl, input bit ack,
                        input logic [31:0] nxt, input logic [31:0] rd);
        reset_n = rn; stall = st; flush = fl; imem_ack = ack;
        next_pc = nxt; imem_rdata = rd;
        @(posedge clk);
        if (!rn) begin
            m_pc = RPC; m_addr = RPC; m_idpc = 32'h0; m_idinstr = NOP; m_buf = 32'h0;
            m_valid = 0; m_started = 0; m_buffered = 0; m_dropping = 0;
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_dropping) begin
            if (fl) m_pc = nxt;
            if (ack) begin m_dropping = 0; m_addr = m_pc; end
            m_valid = 0;
        end else if (m_buffered) begin
            if (fl) begin
                m_buffered = 0; m_valid = 0; m_pc = nxt; m_addr = nxt;
            end else if (!st) begin
                m_idpc = m_pc; m_idinstr = m_buf; m_valid = 1;
                m_pc = nxt; m_addr = nxt; m_buffered = 0;
            end
        end else begin
            if (fl) begin
                m_valid = 0; m_pc = nxt;
                if (ack) m_addr = nxt; else m_dropping = 1;
            end else if (ack && st) begin
                m_buffered = 1; m_buf = rd;
            end else if (ack) begin
                m_idpc = m_pc; m_idinstr = rd; m_valid = 1; m_pc = nxt; m_addr = nxt;
            end else if (!st) begin
                m_valid = 0;
            end
        end
        m_req = m_started && !m_buffered;
        #1;
    endtask

    task automatic do_reset();
        tick(0, 0, 0, 0, 32'h0, 32'h0);
        tick(1, 0, 0, 0, $urandom, $urandom);
    endtask

    task automatic test_reset();
        tick(0, 0, 0, 0, 32'h0, 32'h0);
        tick(0, 1, 1, 1, $urandom, $urandom);
        total++; if (curr_pc !== RPC) begin bad++; $display("FAIL reset_curr_pc got=%h exp=%h", curr_pc, RPC); end
        total++; if (imem_addr !== RPC) begin bad++; $display("FAIL reset_imem_addr got=%h exp=%h", imem_addr, RPC); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_imem_req got=%b exp=0", imem_req); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
        total++; if (id_instr !== NOP) begin bad++; $display("FAIL reset_id_instr got=%h exp=%h", id_instr, NOP); end
        tick(1, 0, 0, 0, $urandom, $urandom);
        total++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin bad++;
            $display("FAIL first_fetch got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, RPC); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL idle_bubble got=%b exp=0", id_valid); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd, exp_pc;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_pc = RPC + 32'(4 * i);
            total++; if (imem_addr !== exp_pc || imem_req !== 1'b1) begin bad++;
                $display("FAIL zw_addr got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, exp_pc); end
            rd = $urandom;
            tick(1, 0, 0, 1, exp_pc + 32'd4, rd);
            total++; if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instr !== rd) begin bad++;
                $display("FAIL zw_ifid got v=%b pc=%h ins=%h exp v=1 pc=%h ins=%h", id_valid, id_pc, id_instr, exp_pc, rd); end
        end
    endtask

    task automatic test_ack_delay();
        logic [31:0] rd;
        do_reset();
        tick(1, 0, 0, 1, RPC + 32'd4, $urandom);
        for (int k = 0; k < 3; k++) begin
            tick(1, 0, 0, 0, $urandom, $urandom);
            total++; if (id_valid !== 1'b0 || id_instr !== NOP) begin bad++;
                $display("FAIL delay_bubble got v=%b ins=%h exp v=0 ins=%h", id_valid, id_instr, NOP); end
            total++; if (imem_addr !== 32'h3004 || imem_req !== 1'b1) begin bad++;
                $display("FAIL delay_addr got req=%b addr=%h exp req=1 addr=00003004", imem_req, imem_addr); end
        end
        rd = $urandom;
        tick(1, 0, 0, 1, 32'h3008, rd);
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h3004 || id_instr !== rd) begin bad++;
            $display("FAIL delay_arrive got v=%b pc=%h ins=%h exp v=1 pc=00003004 ins=%h", id_valid, id_pc, id_instr, rd); end
    endtask

    task automatic test_stall_hold();
        tick(1, 1, 0, 1, 32'h300C, 32'h1234_5678);
        for (int k = 0; k < 2; k++) begin
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL hold_req got=%b exp=0", imem_req); end
            total++; if (id_valid !== 1'b1 || id_pc !== 32'h3004) begin bad++;
                $display("FAIL hold_ifid got v=%b pc=%h exp v=1 pc=00003004", id_valid, id_pc); end
            if (k == 0) tick(1, 1, 0, 0, $urandom, $urandom);
        end
        tick(1, 0, 0, 0, 32'h300C, $urandom);
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h3008 || id_instr !== 32'h1234_5678) begin bad++;
            $display("FAIL hold_release got v=%b pc=%h ins=%h exp v=1 pc=00003008 ins=12345678", id_valid, id_pc, id_instr); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h300C || curr_pc !== 32'h300C) begin bad++;
            $display("FAIL hold_refetch got req=%b addr=%h pc=%h exp req=1 addr=0000300c pc=0000300c", imem_req, imem_addr, curr_pc); end
        tick(1, 0, 0, 0, $urandom, $urandom);
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL hold_once got v=%b exp=0", id_valid); end
    endtask

    task automatic test_flush_drop();
        tick(1, 0, 1, 0, 32'h3100, $urandom);
        total++; if (id_valid !== 1'b0 || curr_pc !== 32'h3100 || imem_addr !== 32'h300C || imem_req !== 1'b1) begin bad++;
            $display("FAIL drop_enter got v=%b pc=%h addr=%h req=%b exp v=0 pc=00003100 addr=0000300c req=1", id_valid, curr_pc, imem_addr, imem_req); end
        tick(1, 0, 0, 0, $urandom, $urandom);
        total++; if (imem_addr !== 32'h300C || id_valid !== 1'b0) begin bad++;
            $display("FAIL drop_wait got addr=%h v=%b exp addr=0000300c v=0", imem_addr, id_valid); end
        tick(1, 0, 0, 1, $urandom, 32'hDEAD_BEEF);
        total++; if (id_valid !== 1'b0 || imem_addr !== 32'h3100 || curr_pc !== 32'h3100) begin bad++;
            $display("FAIL drop_ack got v=%b addr=%h pc=%h exp v=0 addr=00003100 pc=00003100", id_valid, imem_addr, curr_pc); end
        tick(1, 0, 0, 1, 32'h3104, 32'h0BAD_F00D);
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h3100 || id_instr !== 32'h0BAD_F00D) begin bad++;
            $display("FAIL drop_resume got v=%b pc=%h ins=%h exp v=1 pc=00003100 ins=0badf00d", id_valid, id_pc, id_instr); end
    endtask

    task automatic test_flush_stall_ack();
        tick(1, 1, 1, 1, 32'h3200, 32'hCAFE_F00D);
        total++; if (id_valid !== 1'b0 || curr_pc !== 32'h3200 || imem_addr !== 32'h3200 || imem_req !== 1'b1) begin bad++;
            $display("FAIL fsa_cycle got v=%b pc=%h addr=%h req=%b exp v=0 pc=00003200 addr=00003200 req=1", id_valid, curr_pc, imem_addr, imem_req); end
        tick(1, 0, 0, 1, 32'h3204, 32'h1111_1111);
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h3200 || id_instr !== 32'h1111_1111) begin bad++;
            $display("FAIL fsa_next got v=%b pc=%h ins=%h exp v=1 pc=00003200 ins=11111111", id_valid, id_pc, id_instr); end
    endtask

    task automatic test_reset_mid_hold();
        tick(1, 1, 0, 1, $urandom, $urandom);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rmh_hold got req=%b exp=0", imem_req); end
        tick(0, 1, 0, 0, $urandom, $urandom);
        total++; if (curr_pc !== RPC || imem_addr !== RPC || imem_req !== 1'b0 || id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== NOP) begin bad++;
            $display("FAIL rmh_reset got pc=%h addr=%h req=%b v=%b idpc=%h ins=%h exp reset values", curr_pc, imem_addr, imem_req, id_valid, id_pc, id_instr); end
        tick(1, 0, 0, 0, $urandom, $urandom);
        total++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin bad++;
            $display("FAIL rmh_refetch got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, RPC); end
    endtask

    task automatic test_random();
        bit          rn, st, fl, ack;
        logic [31:0] nxt, exp_instr;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rn  = ($urandom_range(0, 99) != 0);
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            ack = m_req && ($urandom_range(0, 2) != 0);
            nxt = ($urandom_range(0, 3) == 0) ? $urandom : m_pc + 32'd4;
            tick(rn, st, fl, ack, nxt, $urandom);
            exp_instr = m_valid ? m_idinstr : NOP;
            total++; if (curr_pc !== m_pc) begin bad++; $display("FAIL rnd_curr_pc cyc=%0d got=%h exp=%h", n, curr_pc, m_pc); end
            total++; if (imem_addr !== m_addr) begin bad++; $display("FAIL rnd_imem_addr cyc=%0d got=%h exp=%h", n, imem_addr, m_addr); end
            total++; if (imem_req !== m_req) begin bad++; $display("FAIL rnd_imem_req cyc=%0d got=%b exp=%b", n, imem_req, m_req); end
            total++; if (id_valid !== m_valid) begin bad++; $display("FAIL rnd_id_valid cyc=%0d got=%b exp=%b", n, id_valid, m_valid); end
            total++; if (id_instr !== exp_instr) begin bad++; $display("FAIL rnd_id_instr cyc=%0d got=%h exp=%h", n, id_instr, exp_instr); end
            total++; if (m_valid && id_pc !== m_idpc) begin bad++; $display("FAIL rnd_id_pc cyc=%0d got=%h exp=%h", n, id_pc, m_idpc); end
        end
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0; imem_ack = 1'b0;
        next_pc = 32'h0; imem_rdata = 32'h0;
        test_reset();
        test_zero_wait();
        test_ack_delay();
        test_stall_hold();
        test_flush_drop();
        test_flush_stall_ack();
        test_reset_mid_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
